// File: rtl/spi_master_wb_cfg.sv
// SPI master with a Wishbone-style register file: mode, clock divider and chip select
// are configured over the bus; a TXDATA write runs one full-duplex transfer.
module spi_master_wb_cfg #(
  parameter int NUM_CHIP_SELECTS = 3,
  parameter int DATA_WIDTH       = 8,
  parameter int RESET_CLKDIV     = 3
) (
  input  logic                        CLK_I,
  input  logic                        RST_I,
  input  logic                        STB_I,
  input  logic                        WE_I,
  input  logic [2:0]                  ADR_I,
  input  logic [DATA_WIDTH-1:0]       DAT_I,
  output logic [DATA_WIDTH-1:0]       DAT_O,
  output logic                        ACK_O,
  output logic                        RTY_O,
  input  logic                        miso,
  output logic                        mosi,
  output logic                        sck,
  output logic [NUM_CHIP_SELECTS-1:0] chipSelects
);

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_CLKDIV = 3'd1;
  localparam logic [2:0] A_CSSEL  = 3'd2;
  localparam logic [2:0] A_TXDATA = 3'd3;
  localparam logic [2:0] A_RXDATA = 3'd4;
  localparam logic [2:0] A_STATUS = 3'd5;
  localparam int EW = $clog2(2 * DATA_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, TRAIL, DONE} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_ack;
  logic                  r_rty;
  logic [DATA_WIDTH-1:0] r_dat;
  logic [3:0]            r_ctrl;
  logic [7:0]            r_clkdiv;
  logic [2:0]            r_cssel;
  logic [DATA_WIDTH-1:0] r_rxdata;
  logic                  r_done;
  logic                  r_cs_held;
  logic [7:0]            r_hp_cnt;
  logic [EW-1:0]         r_edge_cnt;
  logic                  r_sck;
  logic                  r_mosi;
  logic [DATA_WIDTH-1:0] r_tx_sr;
  logic [DATA_WIDTH-1:0] r_rx_sr;

  logic                  w_access;
  logic                  w_busy;
  logic                  w_refuse;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_start;
  logic                  w_hp_end;
  logic                  w_last_edge;
  logic                  w_edge;
  logic                  w_leading;
  logic                  w_sample;
  logic                  w_update;
  logic                  w_cs_active;
  logic                  w_cpol;
  logic                  w_cpha;
  logic                  w_lsb;
  logic [DATA_WIDTH-1:0] w_rd_data;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] v,
                                                      input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  assign w_cpol = r_ctrl[0];
  assign w_cpha = r_ctrl[1];
  assign w_lsb  = r_ctrl[3];

  // A cycle that is already responding never starts a new access.
  assign w_access    = STB_I & ~r_ack & ~r_rty;
  assign w_busy      = (r_state != IDLE);
  assign w_refuse    = w_access & WE_I & w_busy;
  assign w_wr        = w_access & WE_I & ~w_busy;
  assign w_rd        = w_access & ~WE_I;
  assign w_start     = w_wr & (ADR_I == A_TXDATA);
  assign w_hp_end    = (r_hp_cnt == r_clkdiv);
  assign w_last_edge = (r_edge_cnt == EW'(2 * DATA_WIDTH));

  // Odd-numbered edges (1st, 3rd, ...) are leading edges.
  assign w_leading = ~r_edge_cnt[0];
  assign w_sample  = w_edge & (w_cpha ? ~w_leading : w_leading);
  assign w_update  = w_edge & (w_cpha ? w_leading : ~w_leading);

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_edge       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_next = SETUP;
        end
      end
      SETUP: begin
        if (w_hp_end) begin
          w_state_next = SHIFT;
          w_edge       = 1'b1;
        end
      end
      SHIFT: begin
        if (w_hp_end) begin
          if (w_last_edge) begin
            w_state_next = TRAIL;
          end else begin
            w_edge = 1'b1;
          end
        end
      end
      TRAIL: begin
        if (w_hp_end) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    w_rd_data = '0;
    case (ADR_I)
      A_CTRL:   w_rd_data[3:0] = r_ctrl;
      A_CLKDIV: w_rd_data[7:0] = r_clkdiv;
      A_CSSEL:  w_rd_data[2:0] = r_cssel;
      A_RXDATA: w_rd_data      = r_rxdata;
      A_STATUS: w_rd_data[1:0] = {r_done, w_busy};
      default:  w_rd_data      = '0;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_ack      <= 1'b0;
      r_rty      <= 1'b0;
      r_dat      <= '0;
      r_ctrl     <= '0;
      r_clkdiv   <= 8'(RESET_CLKDIV);
      r_cssel    <= '0;
      r_rxdata   <= '0;
      r_done     <= 1'b0;
      r_cs_held  <= 1'b0;
      r_hp_cnt   <= '0;
      r_edge_cnt <= '0;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b0;
      r_tx_sr    <= '0;
      r_rx_sr    <= '0;
    end else begin
      r_ack <= w_access & ~w_refuse;
      r_rty <= w_refuse;
      r_dat <= w_rd ? w_rd_data : '0;

      if (w_wr) begin
        case (ADR_I)
          A_CTRL: begin
            r_ctrl <= DAT_I[3:0];
            if (!DAT_I[2]) begin
              r_cs_held <= 1'b0;
            end
          end
          A_CLKDIV: r_clkdiv <= DAT_I[7:0];
          A_CSSEL: begin
            r_cssel <= DAT_I[2:0];
            if (DAT_I[2:0] != r_cssel) begin
              r_cs_held <= 1'b0;
            end
          end
          default: ;
        endcase
      end

      if (r_state == IDLE) begin
        r_hp_cnt   <= '0;
        r_edge_cnt <= '0;
      end else begin
        r_hp_cnt <= w_hp_end ? 8'd0 : r_hp_cnt + 8'd1;
      end

      // CPHA=0 presents the first bit before any clock edge; CPHA=1 waits for edge 1.
      if (w_start) begin
        r_sck   <= w_cpol;
        r_rx_sr <= '0;
        if (w_cpha) begin
          r_mosi  <= 1'b0;
          r_tx_sr <= DAT_I;
        end else begin
          r_mosi  <= first_bit(DAT_I, w_lsb);
          r_tx_sr <= shift_out(DAT_I, w_lsb);
        end
      end

      if (w_edge) begin
        r_sck      <= ~r_sck;
        r_edge_cnt <= r_edge_cnt + EW'(1);
      end
      if (w_update) begin
        r_mosi  <= first_bit(r_tx_sr, w_lsb);
        r_tx_sr <= shift_out(r_tx_sr, w_lsb);
      end
      if (w_sample) begin
        r_rx_sr <= w_lsb ? {miso, r_rx_sr[DATA_WIDTH-1:1]}
                         : {r_rx_sr[DATA_WIDTH-2:0], miso};
      end

      // Latch the hold request before DONE so a held CS never blips high.
      if (r_state == TRAIL && w_hp_end) begin
        r_cs_held <= r_ctrl[2];
      end
      if (r_state == DONE) begin
        r_rxdata <= r_rx_sr;
      end

      if (r_state == DONE) begin
        r_done <= 1'b1;
      end else if (w_rd && ADR_I == A_RXDATA) begin
        r_done <= 1'b0;
      end
    end
  end

  assign w_cs_active = (r_state == SETUP) || (r_state == SHIFT) || (r_state == TRAIL) || r_cs_held;

  for (genvar gi = 0; gi < NUM_CHIP_SELECTS; gi++) begin : g_cs
    assign chipSelects[gi] = ~(w_cs_active && (r_cssel == 3'(gi)));
  end

  assign ACK_O = r_ack;
  assign RTY_O = r_rty;
  assign DAT_O = r_dat;
  assign sck   = w_busy ? r_sck : w_cpol;
  assign mosi  = w_busy ? r_mosi : 1'b0;

endmodule

// File: doc/spi_master_wb_cfg.md
SPI_MASTER_WB_CFG -- requirements
Module: spi_master_wb_cfg

Interface
REQ-001 Parameter NUM_CHIP_SELECTS, default 3, number of active-low chip-select outputs (1..8).
REQ-002 Parameter DATA_WIDTH, default 8, transfer width in bits and Wishbone data width (8..32).
REQ-003 Parameter RESET_CLKDIV, default 3, CLKDIV register value after reset.
REQ-004 CLK_I  in  1  single system clock; all logic on its rising edge.
REQ-005 RST_I  in  1  reset, synchronous and active-high.
REQ-006 STB_I, WE_I  in  1 each  Wishbone strobe and write enable.
REQ-007 ADR_I  in  3  register address.
REQ-008 DAT_I  in  DATA_WIDTH  write data.
REQ-009 DAT_O  out  DATA_WIDTH  read data, valid while ACK_O=1.
REQ-010 ACK_O, RTY_O  out  1 each  access accepted or refused (busy).
REQ-011 miso  in  1; mosi, sck  out  1 each; chipSelects  out  NUM_CHIP_SELECTS  active low.

Function
REQ-012 Register map SHALL be: 0 CTRL {bit0 CPOL, bit1 CPHA, bit2 CSHOLD, bit3 LSB_FIRST}; 1 CLKDIV (8 bits); 2 CSSEL (3 bits); 3 TXDATA (write starts transfer); 4 RXDATA (read-only); 5 STATUS {bit0 BUSY, bit1 DONE}; 6-7 read 0, writes ignored, ACKed.
REQ-013 Access with STB_I=1 and no response in current cycle SHALL produce exactly one one-cycle response pulse in the next cycle; STB_I held high gives one response per two cycles.
REQ-014 Any write while BUSY=1 SHALL get RTY_O instead of ACK_O and change no state; reads always get ACK_O.
REQ-015 Unused DAT_O bits above register width SHALL read 0.
REQ-016 FSM SHALL have states IDLE, SETUP, SHIFT, TRAIL, DONE.
REQ-017 IDLE: accepted TXDATA write latches data, sets BUSY, goes to SETUP next cycle.
REQ-018 SETUP: chipSelects[CSSEL] low, sck=CPOL, lasts one half-period, then SHIFT.
REQ-019 Half-period SHALL be CLKDIV+1 CLK_I cycles; CLKDIV=0 gives sck = CLK_I/2.
REQ-020 SHIFT: sck toggles every half-period, exactly 2*DATA_WIDTH edges, ending at CPOL; then TRAIL.
REQ-021 CPHA=0: first mosi bit driven on entering SETUP, miso sampled on leading edges, mosi updated on trailing edges. CPHA=1: mosi updated on leading edges, miso sampled on trailing edges.
REQ-022 LSB_FIRST=0 shifts MSB first on both mosi and miso; LSB_FIRST=1 LSB first.
REQ-023 TRAIL: one half-period with CS still low, then DONE.
REQ-024 DONE (one cycle): RXDATA loaded, DONE flag set, BUSY cleared, CS released unless CSHOLD=1; then IDLE.
REQ-025 With CSHOLD=1 CS SHALL stay low in IDLE; a later transfer to the same CSSEL SHALL skip CS deassertion.
REQ-026 A held CS SHALL go high in the cycle after a write clearing CSHOLD or changing CSSEL.
REQ-027 CSSEL >= NUM_CHIP_SELECTS SHALL assert no chip select; the transfer still runs.
REQ-028 DONE flag SHALL clear on RXDATA read; if set and cleared in the same cycle, set wins.
REQ-029 mosi SHALL be 0 and sck SHALL equal CPOL while not BUSY.
REQ-030 CTRL and CLKDIV SHALL be ignored mid-transfer (writes get RTY_O), so mode is constant per transfer.

Reset
REQ-031 RST_I=1 SHALL force IDLE, all chipSelects=1, sck=0, mosi=0, ACK_O=0, RTY_O=0, DAT_O=0, CTRL=0, CLKDIV=RESET_CLKDIV, CSSEL=0, RXDATA=0, STATUS=0.
REQ-032 Reset mid-transfer SHALL abort with the REQ-031 values on the next edge; no RXDATA update, no DONE.

Verification
REQ-033 Mode 0, CLKDIV=0, CSSEL=1, TXDATA=0xA5, miso looped to mosi -> chipSelects=3'b101 for 18 cycles, 16 sck edges, RXDATA=0xA5, STATUS=0x2.
REQ-034 Mode 3 (CPOL=1, CPHA=1), LSB_FIRST=1, miso tied 1, TXDATA=0x01 -> sck idles high, mosi first bit 1, RXDATA=0xFF.
REQ-035 CLKDIV=3: TXDATA write then CTRL write during BUSY -> ACK then RTY_O; sck half-period 4 cycles; CTRL unchanged.
REQ-036 CSHOLD=1, two TXDATA writes to CSSEL=0 -> chipSelects[0] low throughout; CSSEL write to 2 -> chipSelects[0] high next cycle.
REQ-037 RST_I pulse after 5 sck edges -> outputs per REQ-031 next cycle; RXDATA=0, DONE=0.
REQ-038 CSSEL=7 with NUM_CHIP_SELECTS=3 -> all chipSelects stay high; transfer completes, DONE=1.
